// File: rtl/hamming_encode.sv
// hamming_encode: SEC Hamming encoder with error-injection hook and a 2-entry output FIFO
module hamming_encode #(
    parameter int data_width     = 16,
    parameter int encoding_width = 21
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [data_width-1:0]     data_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic                      inject_en,
    input  logic [4:0]                inject_pos,
    output logic [encoding_width-1:0] encoded_data,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [15:0]               word_count
);
    localparam int P = encoding_width - data_width;

    logic [encoding_width-1:0] mem [2];
    logic [encoding_width-1:0] code;
    logic [encoding_width-1:0] flip;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                occ;
    logic                      push;
    logic                      pop;

    // Data fills non-power-of-two positions LSB first; parity at 2^k covers positions with bit k set
    function automatic logic [encoding_width-1:0] encode(input logic [data_width-1:0] d);
        logic [encoding_width-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i <= encoding_width; i++)
            if ((i & (i - 1)) != 0) begin
                c[i-1] = d[j];
                j++;
            end
        for (int k = 0; k < P; k++)
            for (int i = 1; i <= encoding_width; i++)
                if (((i >> k) & 1) != 0 && (i & (i - 1)) != 0)
                    c[(1 << k) - 1] = c[(1 << k) - 1] ^ c[i-1];
        return c;
    endfunction

    // Codeword and injection mask for the word offered this cycle
    always_comb begin
        code = encode(data_in);
        flip = (inject_en && 32'(inject_pos) < encoding_width)
             ? {{(encoding_width-1){1'b0}}, 1'b1} << inject_pos : '0;
    end

    assign push         = valid_in && ready_out;
    assign pop          = valid_out && ready_in;
    assign valid_out    = occ != 2'd0;
    assign ready_out    = occ != 2'd2;
    assign encoded_data = mem[rd_ptr];

    // FIFO storage, pointers, occupancy and accepted-word counter
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            word_count <= 16'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= code ^ flip;
                wr_ptr      <= ~wr_ptr;
                word_count  <= word_count + 16'd1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_hamming_encode.sv
// tb_hamming_encode: directed checks of encoding, injection, backpressure, reset and counter wrap
module tb_hamming_encode;
    logic        clk = 1'b0;
    logic        rstb;
    logic [15:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        inject_en;
    logic [4:0]  inject_pos;
    logic [20:0] encoded_data;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] word_count;
    int          n_cmp = 0;
    int          n_err = 0;

    hamming_encode dut (
        .clk(clk), .rstb(rstb), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .inject_en(inject_en), .inject_pos(inject_pos),
        .encoded_data(encoded_data), .valid_out(valid_out), .ready_in(ready_in),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one word at a falling edge, let it be accepted, then check it at the head
    task automatic push_check(input logic [15:0] d, input logic en, input logic [4:0] pos,
                              input logic [31:0] exp, input string tag);
        data_in    = d;
        inject_en  = en;
        inject_pos = pos;
        valid_in   = 1'b1;
        @(negedge clk);
        valid_in  = 1'b0;
        inject_en = 1'b0;
        check({tag, "_valid"}, 32'(valid_out), 1);
        check(tag, 32'(encoded_data), exp);
    endtask

    initial begin
        rstb       = 1'b1;
        data_in    = '0;
        valid_in   = 1'b0;
        inject_en  = 1'b0;
        inject_pos = '0;
        ready_in   = 1'b1;
        #1;
        check("rst_valid", 32'(valid_out), 0);
        check("rst_data", 32'(encoded_data), 0);
        check("rst_count", 32'(word_count), 0);
        check("rst_ready", 32'(ready_out), 1);
        @(negedge clk);
        rstb = 1'b0;

        push_check(16'd10, 1'b0, 5'd0, 82, "enc10");
        check("count1", 32'(word_count), 1);

        data_in  = 16'd19008;
        valid_in = 1'b1;
        @(negedge clk);
        check("stream_a", 32'(encoded_data), 599040);
        check("stream_a_valid", 32'(valid_out), 1);
        data_in = 16'd44561;
        @(negedge clk);
        check("stream_b", 32'(encoded_data), 1433996);
        check("stream_b_valid", 32'(valid_out), 1);
        valid_in = 1'b0;
        @(negedge clk);
        check("stream_drained", 32'(valid_out), 0);
        check("count3", 32'(word_count), 3);

        push_check(16'd19008, 1'b1, 5'd7, 599168, "inj7");
        push_check(16'd19008, 1'b1, 5'd6, 599104, "inj6");
        push_check(16'd19008, 1'b1, 5'd19, 74752, "inj19");
        push_check(16'd19008, 1'b1, 5'd25, 599040, "inj25");
        push_check(16'd19008, 1'b1, 5'd21, 599040, "inj21");
        @(negedge clk);
        check("count8", 32'(word_count), 8);

        ready_in = 1'b0;
        data_in  = 16'd10;
        valid_in = 1'b1;
        @(negedge clk);
        check("bp_ready1", 32'(ready_out), 1);
        check("bp_head1", 32'(encoded_data), 82);
        data_in = 16'd19008;
        @(negedge clk);
        check("bp_ready2", 32'(ready_out), 0);
        check("bp_head2", 32'(encoded_data), 82);
        data_in = 16'd44561;
        @(negedge clk);
        check("bp_hold_ready", 32'(ready_out), 0);
        check("bp_hold_count", 32'(word_count), 10);
        ready_in = 1'b1;
        @(negedge clk);
        check("bp_out2", 32'(encoded_data), 599040);
        check("bp_ready3", 32'(ready_out), 1);
        @(negedge clk);
        check("bp_out3", 32'(encoded_data), 1433996);
        check("bp_valid3", 32'(valid_out), 1);
        valid_in = 1'b0;
        @(negedge clk);
        check("bp_drained", 32'(valid_out), 0);
        check("count11", 32'(word_count), 11);

        ready_in = 1'b0;
        data_in  = 16'd10;
        valid_in = 1'b1;
        @(negedge clk);
        data_in = 16'd19008;
        @(negedge clk);
        valid_in = 1'b0;
        check("pre_rst_full", 32'(ready_out), 0);
        rstb = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid_out), 0);
        check("mid_rst_data", 32'(encoded_data), 0);
        check("mid_rst_count", 32'(word_count), 0);
        check("mid_rst_ready", 32'(ready_out), 1);
        @(negedge clk);
        rstb     = 1'b0;
        ready_in = 1'b1;
        push_check(16'd10, 1'b0, 5'd0, 82, "post_rst");
        check("post_rst_count", 32'(word_count), 1);

        data_in  = 16'd44561;
        valid_in = 1'b1;
        repeat (65534) @(negedge clk);
        check("count_max", 32'(word_count), 65535);
        check("wrap_stream", 32'(encoded_data), 1433996);
        @(negedge clk);
        valid_in = 1'b0;
        check("count_wrap", 32'(word_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
